// File: rtl/blit_pkg.sv
// -----------------------------------------------------------------------------
// blit_pkg
// Shared definitions for the blitter command front end:
//   - command opcodes (top byte of a command word)
//   - op_kind encoding presented to the line / rect engines
//   - dispatch FSM state encoding
//   - payload field offsets as functions of the coordinate width
// -----------------------------------------------------------------------------
package blit_pkg;

    // Command opcodes
    localparam logic [7:0] OP_SET_DEST      = 8'h01;
    localparam logic [7:0] OP_SET_SRC       = 8'h02;
    localparam logic [7:0] OP_FILL_RECT     = 8'h03;
    localparam logic [7:0] OP_COPY_RECT     = 8'h04;
    localparam logic [7:0] OP_COPY_RECT_REV = 8'h05;
    localparam logic [7:0] OP_SET_CLIP      = 8'h06;
    localparam logic [7:0] OP_SET_TRANS     = 8'h07;
    localparam logic [7:0] OP_SET_FONT      = 8'h08;
    localparam logic [7:0] OP_DRAW_CHAR     = 8'h09;
    localparam logic [7:0] OP_DRAW_LINE     = 8'h0A;

    // Operation kinds seen by the engines
    localparam logic [1:0] KIND_LINE = 2'd0;
    localparam logic [1:0] KIND_FILL = 2'd1;
    localparam logic [1:0] KIND_COPY = 2'd2;
    localparam logic [1:0] KIND_CHAR = 2'd3;

    // Dispatch FSM
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RUN   = 2'd2
    } dispatch_state_e;

    // Payload field fN starts at bit N*coord_w; the opcode sits above f5.
    function automatic int field_lsb(input int idx, input int coord_w);
        return idx * coord_w;
    endfunction

    function automatic int opcode_lsb(input int coord_w);
        return 6 * coord_w;
    endfunction

    function automatic logic is_draw(input logic [7:0] opc);
        return (opc == OP_FILL_RECT) || (opc == OP_COPY_RECT) ||
               (opc == OP_COPY_RECT_REV) || (opc == OP_DRAW_CHAR) ||
               (opc == OP_DRAW_LINE);
    endfunction

    function automatic logic [1:0] kind_of(input logic [7:0] opc);
        logic [1:0] k;
        k = KIND_LINE;
        case (opc)
            OP_FILL_RECT:                   k = KIND_FILL;
            OP_COPY_RECT, OP_COPY_RECT_REV: k = KIND_COPY;
            OP_DRAW_CHAR:                   k = KIND_CHAR;
            default:                        k = KIND_LINE;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/blit_cmd_fifo.sv
// -----------------------------------------------------------------------------
// blit_cmd_fifo
// Small synchronous FIFO holding command words plus their context tag.
// The head entry is presented combinationally from storage so the consumer
// can decode it in the cycle after it was pushed.
//
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset (empties the FIFO)
//   stall_i          blocks both push and pop
//   push_i/push_data_i  write request (ignored when full or stalled)
//   pop_i            remove head (ignored when empty or stalled)
//   head_o           current head entry (valid when !empty_o)
//   empty_o, full_o  occupancy flags
// -----------------------------------------------------------------------------
module blit_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic do_push;
    logic do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign do_push = push_i && !full_o && !stall_i;
    assign do_pop  = pop_i && !empty_o && !stall_i;
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by count_q.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/blit_cmd_dispatch.sv
// -----------------------------------------------------------------------------
// blit_cmd_dispatch
// Blitter command front end. Buffers command words in a FIFO, maintains
// per-context state banks (destination, source, clip, transparent colour,
// font), and dispatches draw operations to the line / rect engines.
//
// Handshakes:
//   cmd_in: a word is accepted on a rising clock edge where cmd_in_valid_i and
//     cmd_in_ready_o are both high; ready is !full && !stall and never depends
//     on a same-cycle pop. op: op_valid_o rises with a one-cycle op_start_o and
//     stays high, with all op_* fields stable, until the matching done
//     (line_done_i for kind 0, rect_done_i otherwise) is seen in a cycle after
//     op_start_o; op_valid_o drops the following cycle.
//
// Ports (all _i inputs, _o outputs):
//   clk_i, rst_i, stall_i       clock, async active-high reset, global freeze
//   cmd_in_*                    command push interface with context tag
//   op_*                        registered draw operation to the engines
//   line_done_i, rect_done_i    engine completion strobes
//   busy_o                      FIFO non-empty or op in flight
//   bad_cmd_count_o             saturating unknown-opcode counter
//   dbg_state_o                 dispatch FSM state
// -----------------------------------------------------------------------------
module blit_cmd_dispatch
    import blit_pkg::*;
#(
    parameter int COORD_W    = 16,
    parameter int ADDR_W     = 26,
    parameter int COLOR_W    = 9,
    parameter int FIFO_DEPTH = 4,
    parameter int NUM_CTX    = 2,
    localparam int CMD_W     = 8 + 6 * COORD_W,
    localparam int CTX_W     = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               stall_i,
    input  logic [CMD_W-1:0]   cmd_in_i,
    input  logic [CTX_W-1:0]   cmd_in_ctx_i,
    input  logic               cmd_in_valid_i,
    output logic               cmd_in_ready_o,
    output logic               op_valid_o,
    output logic               op_start_o,
    output logic [1:0]         op_kind_o,
    output logic [COORD_W-1:0] op_x1_o,
    output logic [COORD_W-1:0] op_y1_o,
    output logic [COORD_W-1:0] op_x2_o,
    output logic [COORD_W-1:0] op_y2_o,
    output logic [COORD_W-1:0] op_width_o,
    output logic [COORD_W-1:0] op_height_o,
    output logic               op_reversed_o,
    output logic               op_textmode_o,
    output logic               op_mem_read_o,
    output logic [7:0]         op_char_o,
    output logic [COLOR_W-1:0] op_fg_o,
    output logic [COLOR_W-1:0] op_bg_o,
    output logic [COLOR_W-1:0] op_trans_o,
    output logic [COORD_W-1:0] op_clip_x1_o,
    output logic [COORD_W-1:0] op_clip_y1_o,
    output logic [COORD_W-1:0] op_clip_x2_o,
    output logic [COORD_W-1:0] op_clip_y2_o,
    output logic [31:0]        op_src_addr_o,
    output logic [COORD_W-1:0] op_src_bpr_o,
    output logic [ADDR_W-1:0]  op_dest_addr_o,
    output logic [COORD_W-1:0] op_dest_bpr_o,
    output logic [7:0]         op_font_bpc_o,
    input  logic               line_done_i,
    input  logic               rect_done_i,
    output logic               busy_o,
    output logic [7:0]         bad_cmd_count_o,
    output logic [1:0]         dbg_state_o
);

    // Banks are sized to the full tag range so any tag value indexes safely.
    localparam int NUM_BANKS = 1 << CTX_W;

    // ---------------------------------------------------------------- FIFO
    logic [CMD_W+CTX_W-1:0] fifo_head;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   fifo_pop;

    assign cmd_in_ready_o = !fifo_full && !stall_i;

    blit_cmd_fifo #(
        .WIDTH (CMD_W + CTX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .stall_i     (stall_i),
        .push_i      (cmd_in_valid_i),
        .push_data_i ({cmd_in_ctx_i, cmd_in_i}),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

    // ------------------------------------------------------- head decode
    logic [CMD_W-1:0]     head_cmd;
    logic [CTX_W-1:0]     head_ctx;
    logic [7:0]           head_opc;
    logic [COORD_W-1:0]   f [6];
    logic [2*COORD_W-1:0] f10;

    assign head_cmd = fifo_head[CMD_W-1:0];
    assign head_ctx = fifo_head[CMD_W +: CTX_W];
    assign head_opc = head_cmd[opcode_lsb(COORD_W) +: 8];
    assign f10      = {f[1], f[0]};

    for (genvar i = 0; i < 6; i++) begin : g_fields
        assign f[i] = head_cmd[field_lsb(i, COORD_W) +: COORD_W];
    end

    // ------------------------------------------------------ state / banks
    dispatch_state_e state_q;
    logic [7:0]      bad_cnt_q;

    logic [ADDR_W-1:0]  dest_addr_q [NUM_BANKS];
    logic [COORD_W-1:0] dest_bpr_q  [NUM_BANKS];
    logic [31:0]        src_addr_q  [NUM_BANKS];
    logic [COORD_W-1:0] src_bpr_q   [NUM_BANKS];
    logic [COORD_W-1:0] clip_x1_q   [NUM_BANKS];
    logic [COORD_W-1:0] clip_y1_q   [NUM_BANKS];
    logic [COORD_W-1:0] clip_x2_q   [NUM_BANKS];
    logic [COORD_W-1:0] clip_y2_q   [NUM_BANKS];
    logic [COLOR_W-1:0] trans_q     [NUM_BANKS];
    logic [31:0]        font_addr_q [NUM_BANKS];
    logic [4:0]         font_w_q    [NUM_BANKS];
    logic [4:0]         font_h_q    [NUM_BANKS];
    logic [4:0]         font_bpr_q  [NUM_BANKS];
    logic [7:0]         font_bpc_q  [NUM_BANKS];

    // Registered op outputs
    logic               op_valid_q, op_start_q;
    logic [1:0]         op_kind_q;
    logic [COORD_W-1:0] op_x1_q, op_y1_q, op_x2_q, op_y2_q;
    logic [COORD_W-1:0] op_width_q, op_height_q;
    logic               op_reversed_q, op_textmode_q, op_mem_read_q;
    logic [7:0]         op_char_q;
    logic [COLOR_W-1:0] op_fg_q, op_bg_q, op_trans_q;
    logic [COORD_W-1:0] op_clip_x1_q, op_clip_y1_q, op_clip_x2_q, op_clip_y2_q;
    logic [31:0]        op_src_addr_q;
    logic [COORD_W-1:0] op_src_bpr_q;
    logic [ADDR_W-1:0]  op_dest_addr_q;
    logic [COORD_W-1:0] op_dest_bpr_q;
    logic [7:0]         op_font_bpc_q;

    // Done is only honoured after the op_start cycle.
    logic done_match;
    logic done_accept;

    assign done_match  = (op_kind_q == KIND_LINE) ? line_done_i : rect_done_i;
    assign done_accept = (state_q == ST_RUN) && !op_start_q && done_match;

    // Set-commands and unknown opcodes retire straight from IDLE; draws stay
    // at the head until their engine reports completion.
    always_comb begin
        fifo_pop = 1'b0;
        if (!stall_i && !fifo_empty) begin
            if (state_q == ST_IDLE && !is_draw(head_opc)) fifo_pop = 1'b1;
            if (done_accept)                              fifo_pop = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= ST_IDLE;
            bad_cnt_q      <= '0;
            op_valid_q     <= 1'b0;
            op_start_q     <= 1'b0;
            op_kind_q      <= '0;
            op_x1_q        <= '0;
            op_y1_q        <= '0;
            op_x2_q        <= '0;
            op_y2_q        <= '0;
            op_width_q     <= '0;
            op_height_q    <= '0;
            op_reversed_q  <= 1'b0;
            op_textmode_q  <= 1'b0;
            op_mem_read_q  <= 1'b0;
            op_char_q      <= '0;
            op_fg_q        <= '0;
            op_bg_q        <= '0;
            op_trans_q     <= '0;
            op_clip_x1_q   <= '0;
            op_clip_y1_q   <= '0;
            op_clip_x2_q   <= '0;
            op_clip_y2_q   <= '0;
            op_src_addr_q  <= '0;
            op_src_bpr_q   <= '0;
            op_dest_addr_q <= '0;
            op_dest_bpr_q  <= '0;
            op_font_bpc_q  <= '0;
            for (int c = 0; c < NUM_BANKS; c++) begin
                dest_addr_q[c] <= '0;
                dest_bpr_q[c]  <= '0;
                src_addr_q[c]  <= '0;
                src_bpr_q[c]   <= '0;
                clip_x1_q[c]   <= '0;
                clip_y1_q[c]   <= '0;
                clip_x2_q[c]   <= '0;
                clip_y2_q[c]   <= '0;
                trans_q[c]     <= '1;
                font_addr_q[c] <= '0;
                font_w_q[c]    <= '0;
                font_h_q[c]    <= '0;
                font_bpr_q[c]  <= '0;
                font_bpc_q[c]  <= '0;
            end
        end else if (!stall_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        case (head_opc)
                            OP_SET_DEST: begin
                                dest_addr_q[head_ctx] <= ADDR_W'(f10);
                                dest_bpr_q[head_ctx]  <= f[2];
                            end
                            OP_SET_SRC: begin
                                src_addr_q[head_ctx] <= 32'(f10);
                                src_bpr_q[head_ctx]  <= f[2];
                            end
                            OP_SET_CLIP: begin
                                clip_x1_q[head_ctx] <= f[0];
                                clip_y1_q[head_ctx] <= f[1];
                                clip_x2_q[head_ctx] <= f[2];
                                clip_y2_q[head_ctx] <= f[3];
                            end
                            OP_SET_TRANS: trans_q[head_ctx] <= f[0][COLOR_W-1:0];
                            OP_SET_FONT: begin
                                font_addr_q[head_ctx] <= 32'(f10);
                                font_w_q[head_ctx]    <= f[2][4:0];
                                font_h_q[head_ctx]    <= f[3][4:0];
                                font_bpr_q[head_ctx]  <= f[4][4:0];
                                font_bpc_q[head_ctx]  <= f[5][7:0];
                            end
                            OP_FILL_RECT, OP_COPY_RECT, OP_COPY_RECT_REV,
                            OP_DRAW_CHAR, OP_DRAW_LINE: state_q <= ST_ISSUE;
                            default: begin
                                if (bad_cnt_q != 8'hFF) bad_cnt_q <= bad_cnt_q + 8'd1;
                            end
                        endcase
                    end
                end

                ST_ISSUE: begin
                    // Context-wide fields come from the head's bank, which
                    // already reflects any set-command retired ahead of it.
                    op_valid_q     <= 1'b1;
                    op_start_q     <= 1'b1;
                    op_kind_q      <= kind_of(head_opc);
                    op_x1_q        <= f[2];
                    op_y1_q        <= f[3];
                    op_x2_q        <= '0;
                    op_y2_q        <= '0;
                    op_width_q     <= '0;
                    op_height_q    <= '0;
                    op_reversed_q  <= 1'b0;
                    op_textmode_q  <= 1'b0;
                    op_mem_read_q  <= 1'b0;
                    op_char_q      <= '0;
                    op_fg_q        <= '0;
                    op_bg_q        <= '0;
                    op_trans_q     <= trans_q[head_ctx];
                    op_clip_x1_q   <= clip_x1_q[head_ctx];
                    op_clip_y1_q   <= clip_y1_q[head_ctx];
                    op_clip_x2_q   <= clip_x2_q[head_ctx];
                    op_clip_y2_q   <= clip_y2_q[head_ctx];
                    op_src_addr_q  <= src_addr_q[head_ctx];
                    op_src_bpr_q   <= src_bpr_q[head_ctx];
                    op_dest_addr_q <= dest_addr_q[head_ctx];
                    op_dest_bpr_q  <= dest_bpr_q[head_ctx];
                    op_font_bpc_q  <= font_bpc_q[head_ctx];
                    case (head_opc)
                        OP_DRAW_LINE: begin
                            op_x2_q <= f[0];
                            op_y2_q <= f[1];
                            op_fg_q <= f[4][COLOR_W-1:0];
                        end
                        OP_FILL_RECT: begin
                            op_width_q  <= f[0];
                            op_height_q <= f[1];
                            op_x2_q     <= f[4];
                            op_y2_q     <= f[5];
                            op_fg_q     <= f[4][COLOR_W-1:0];
                        end
                        OP_COPY_RECT, OP_COPY_RECT_REV: begin
                            op_width_q    <= f[0];
                            op_height_q   <= f[1];
                            op_x2_q       <= f[4];
                            op_y2_q       <= f[5];
                            op_mem_read_q <= 1'b1;
                            op_reversed_q <= (head_opc == OP_COPY_RECT_REV);
                        end
                        OP_DRAW_CHAR: begin
                            op_char_q     <= f[0][7:0];
                            op_fg_q       <= f[4][COLOR_W-1:0];
                            op_bg_q       <= f[5][COLOR_W-1:0];
                            op_width_q    <= COORD_W'(font_w_q[head_ctx]);
                            op_height_q   <= COORD_W'(font_h_q[head_ctx]);
                            op_textmode_q <= 1'b1;
                            op_mem_read_q <= 1'b1;
                            op_src_addr_q <= font_addr_q[head_ctx];
                            op_src_bpr_q  <= COORD_W'(font_bpr_q[head_ctx]);
                        end
                        default: ;
                    endcase
                    state_q <= ST_RUN;
                end

                ST_RUN: begin
                    op_start_q <= 1'b0;
                    if (done_accept) begin
                        op_valid_q <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------ outputs
    assign op_valid_o      = op_valid_q;
    assign op_start_o      = op_start_q;
    assign op_kind_o       = op_kind_q;
    assign op_x1_o         = op_x1_q;
    assign op_y1_o         = op_y1_q;
    assign op_x2_o         = op_x2_q;
    assign op_y2_o         = op_y2_q;
    assign op_width_o      = op_width_q;
    assign op_height_o     = op_height_q;
    assign op_reversed_o   = op_reversed_q;
    assign op_textmode_o   = op_textmode_q;
    assign op_mem_read_o   = op_mem_read_q;
    assign op_char_o       = op_char_q;
    assign op_fg_o         = op_fg_q;
    assign op_bg_o         = op_bg_q;
    assign op_trans_o      = op_trans_q;
    assign op_clip_x1_o    = op_clip_x1_q;
    assign op_clip_y1_o    = op_clip_y1_q;
    assign op_clip_x2_o    = op_clip_x2_q;
    assign op_clip_y2_o    = op_clip_y2_q;
    assign op_src_addr_o   = op_src_addr_q;
    assign op_src_bpr_o    = op_src_bpr_q;
    assign op_dest_addr_o  = op_dest_addr_q;
    assign op_dest_bpr_o   = op_dest_bpr_q;
    assign op_font_bpc_o   = op_font_bpc_q;
    assign busy_o          = !fifo_empty || (state_q != ST_IDLE);
    assign bad_cmd_count_o = bad_cnt_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_blit_cmd_dispatch.sv
// -----------------------------------------------------------------------------
// tb_blit_cmd_dispatch
// Directed bench for blit_cmd_dispatch. Inputs change and outputs are sampled
// on the falling clock edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_blit_cmd_dispatch;

    localparam int COORD_W = 16;
    localparam int ADDR_W  = 26;
    localparam int COLOR_W = 9;
    localparam int CMD_W   = 8 + 6 * COORD_W;
    localparam int CTX_W   = 1;

    // ---------------------------------------------------- clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic               stall = 1'b0;
    logic [CMD_W-1:0]   cmd_in = '0;
    logic [CTX_W-1:0]   cmd_ctx = '0;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic               op_valid, op_start;
    logic [1:0]         op_kind;
    logic [COORD_W-1:0] op_x1, op_y1, op_x2, op_y2, op_width, op_height;
    logic               op_reversed, op_textmode, op_mem_read;
    logic [7:0]         op_char;
    logic [COLOR_W-1:0] op_fg, op_bg, op_trans;
    logic [COORD_W-1:0] clip_x1, clip_y1, clip_x2, clip_y2;
    logic [31:0]        op_src_addr;
    logic [COORD_W-1:0] op_src_bpr;
    logic [ADDR_W-1:0]  op_dest_addr;
    logic [COORD_W-1:0] op_dest_bpr;
    logic [7:0]         op_font_bpc;
    logic               line_done = 1'b0;
    logic               rect_done = 1'b0;
    logic               busy;
    logic [7:0]         bad_count;
    logic [1:0]         dbg_state;

    blit_cmd_dispatch dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .stall_i         (stall),
        .cmd_in_i        (cmd_in),
        .cmd_in_ctx_i    (cmd_ctx),
        .cmd_in_valid_i  (cmd_valid),
        .cmd_in_ready_o  (cmd_ready),
        .op_valid_o      (op_valid),
        .op_start_o      (op_start),
        .op_kind_o       (op_kind),
        .op_x1_o         (op_x1),
        .op_y1_o         (op_y1),
        .op_x2_o         (op_x2),
        .op_y2_o         (op_y2),
        .op_width_o      (op_width),
        .op_height_o     (op_height),
        .op_reversed_o   (op_reversed),
        .op_textmode_o   (op_textmode),
        .op_mem_read_o   (op_mem_read),
        .op_char_o       (op_char),
        .op_fg_o         (op_fg),
        .op_bg_o         (op_bg),
        .op_trans_o      (op_trans),
        .op_clip_x1_o    (clip_x1),
        .op_clip_y1_o    (clip_y1),
        .op_clip_x2_o    (clip_x2),
        .op_clip_y2_o    (clip_y2),
        .op_src_addr_o   (op_src_addr),
        .op_src_bpr_o    (op_src_bpr),
        .op_dest_addr_o  (op_dest_addr),
        .op_dest_bpr_o   (op_dest_bpr),
        .op_font_bpc_o   (op_font_bpc),
        .line_done_i     (line_done),
        .rect_done_i     (rect_done),
        .busy_o          (busy),
        .bad_cmd_count_o (bad_count),
        .dbg_state_o     (dbg_state)
    );

    int n_vec  = 0;
    int n_fail = 0;

    // ------------------------------------------------------------ helpers
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CMD_W-1:0] mk(input logic [7:0] op,
                                            input logic [15:0] a0, input logic [15:0] a1,
                                            input logic [15:0] a2, input logic [15:0] a3,
                                            input logic [15:0] a4, input logic [15:0] a5);
        return {op, a5, a4, a3, a2, a1, a0};
    endfunction

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic push(input logic [CMD_W-1:0] c, input logic [CTX_W-1:0] x);
        int w;
        w = 0;
        while (!cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) chk("push_ready_timeout", cmd_ready, 1'b1);
        cmd_in    = c;
        cmd_ctx   = x;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Counts falling edges until op_start is seen.
    task automatic wait_start(input string tag, output int cyc);
        cyc = 0;
        while (!op_start && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 50) chk({tag, "_start_timeout"}, op_start, 1'b1);
    endtask

    // Called at the op_start falling edge: completes the op with a one-cycle done.
    task automatic finish_op(input string tag, input logic is_line);
        @(negedge clk);
        chk({tag, "_start_pulse"}, op_start, 1'b0);
        chk({tag, "_valid_held"}, op_valid, 1'b1);
        if (is_line) line_done = 1'b1; else rect_done = 1'b1;
        @(negedge clk);
        line_done = 1'b0;
        rect_done = 1'b0;
        chk({tag, "_valid_drop"}, op_valid, 1'b0);
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        int lat;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_op_valid", op_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_bad", bad_count, 8'd0);
        chk("rst_ready", cmd_ready, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_state", dbg_state, 2'd0);

        // DRAW_CHAR with no SET_TRANS: reset transparent colour
        push(mk(8'h09, 16'h0041, 0, 16'd1, 16'd2, 16'd3, 16'd4), 1'b0);
        wait_start("char0", lat);
        chk("char0_latency", lat, 2);
        chk("char0_trans", op_trans, 9'h1FF);
        chk("char0_kind", op_kind, 2'd3);
        chk("char0_char", op_char, 8'h41);
        chk("char0_fg", op_fg, 9'd3);
        chk("char0_bg", op_bg, 9'd4);
        chk("char0_busy", busy, 1'b1);
        chk("char0_bad", bad_count, 8'd0);
        finish_op("char0", 1'b0);
        chk("char0_idle_busy", busy, 1'b0);

        // Per-context destinations, fill in ctx1
        push(mk(8'h01, 16'h2345, 16'h0001, 16'd640, 0, 0, 0), 1'b0);
        push(mk(8'h01, 16'h0000, 16'h0002, 16'd320, 0, 0, 0), 1'b1);
        push(mk(8'h03, 16'd10, 16'd4, 16'd3, 16'd5, 16'd7, 16'd8), 1'b1);
        wait_start("fill", lat);
        chk("fill_latency", lat, 2);
        chk("fill_dest_addr", op_dest_addr, 26'h20000);
        chk("fill_dest_bpr", op_dest_bpr, 16'd320);
        chk("fill_kind", op_kind, 2'd1);
        chk("fill_width", op_width, 16'd10);
        chk("fill_height", op_height, 16'd4);
        chk("fill_x1", op_x1, 16'd3);
        chk("fill_y1", op_y1, 16'd5);
        chk("fill_fg", op_fg, 9'd7);
        chk("fill_mem_read", op_mem_read, 1'b0);
        finish_op("fill", 1'b0);

        // Line in ctx0, done held high from op_start
        push(mk(8'h0A, 16'd100, 16'd50, 16'd0, 16'd0, 16'd5, 0), 1'b0);
        wait_start("line", lat);
        chk("line_latency", lat, 2);
        chk("line_kind", op_kind, 2'd0);
        chk("line_x2", op_x2, 16'd100);
        chk("line_y2", op_y2, 16'd50);
        chk("line_dest_addr", op_dest_addr, 26'h12345);
        chk("line_dest_bpr", op_dest_bpr, 16'd640);
        line_done = 1'b1;
        @(negedge clk);
        chk("line_done_ignored", op_valid, 1'b1);
        @(negedge clk);
        chk("line_done_taken", op_valid, 1'b0);
        line_done = 1'b0;
        chk("line_idle", dbg_state, 2'd0);

        // Source surface and reversed copy
        push(mk(8'h02, 16'hBEEF, 16'hDEAD, 16'd1280, 0, 0, 0), 1'b0);
        push(mk(8'h05, 16'd16, 16'd8, 16'd1, 16'd2, 16'd50, 16'd60), 1'b0);
        wait_start("copy", lat);
        chk("copy_kind", op_kind, 2'd2);
        chk("copy_rev", op_reversed, 1'b1);
        chk("copy_mem_read", op_mem_read, 1'b1);
        chk("copy_src_addr", op_src_addr, 32'hDEADBEEF);
        chk("copy_src_bpr", op_src_bpr, 16'd1280);
        chk("copy_x2", op_x2, 16'd50);
        chk("copy_y2", op_y2, 16'd60);
        chk("copy_textmode", op_textmode, 1'b0);
        finish_op("copy", 1'b0);

        // Stall in first op cycle, then fill the FIFO behind a running rect
        push(mk(8'h03, 16'd2, 16'd2, 16'd0, 16'd0, 16'd9, 16'd9), 1'b0);
        wait_start("hold", lat);
        stall = 1'b1;
        @(negedge clk);
        chk("stall_start_held", op_start, 1'b1);
        chk("stall_ready", cmd_ready, 1'b0);
        stall = 1'b0;
        push(mk(8'h07, 16'h00AB, 0, 0, 0, 0, 0), 1'b0);
        push(mk(8'h06, 16'd1, 16'd2, 16'd300, 16'd200, 0, 0), 1'b0);
        push(mk(8'h00, 0, 0, 0, 0, 0, 0), 1'b0);
        chk("full_ready", cmd_ready, 1'b0);
        chk("full_valid", op_valid, 1'b1);
        rect_done = 1'b1;
        @(negedge clk);
        rect_done = 1'b0;
        chk("pop_ready", cmd_ready, 1'b1);
        chk("pop_valid", op_valid, 1'b0);
        push(mk(8'h0A, 16'd40, 16'd41, 16'd42, 16'd43, 16'h0155, 0), 1'b0);
        wait_start("line2", lat);
        chk("line2_trans", op_trans, 9'h0AB);
        chk("line2_clip_x1", clip_x1, 16'd1);
        chk("line2_clip_y1", clip_y1, 16'd2);
        chk("line2_clip_x2", clip_x2, 16'd300);
        chk("line2_clip_y2", clip_y2, 16'd200);
        chk("line2_fg", op_fg, 9'h155);
        chk("line2_bad", bad_count, 8'd1);
        finish_op("line2", 1'b1);

        // Unknown opcodes: one pop per cycle, counter saturates
        for (int i = 0; i < 300; i++) push(mk(8'hFF, 0, 0, 0, 0, 0, 0), 1'b0);
        @(negedge clk);
        chk("bad_drained", busy, 1'b0);
        chk("bad_saturated", bad_count, 8'd255);

        // Font in ctx1, character draw, then reset mid-RUN
        push(mk(8'h08, 16'h5678, 16'h0001, 16'd8, 16'd12, 16'd1, 16'd12), 1'b1);
        push(mk(8'h09, 16'h0041, 0, 16'd20, 16'd30, 16'd2, 16'd3), 1'b1);
        wait_start("char1", lat);
        chk("char1_latency", lat, 2);
        chk("char1_width", op_width, 16'd8);
        chk("char1_height", op_height, 16'd12);
        chk("char1_src_bpr", op_src_bpr, 16'd1);
        chk("char1_bpc", op_font_bpc, 8'd12);
        chk("char1_textmode", op_textmode, 1'b1);
        chk("char1_mem_read", op_mem_read, 1'b1);
        chk("char1_src_addr", op_src_addr, 32'h00015678);
        chk("char1_x2", op_x2, 16'd0);
        chk("char1_dest", op_dest_addr, 26'h20000);
        @(negedge clk);
        chk("char1_running", op_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("abort_valid", op_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_state", dbg_state, 2'd0);
        chk("abort_bad", bad_count, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Banks cleared by reset
        push(mk(8'h09, 16'h0042, 0, 16'd5, 16'd6, 16'd1, 16'd1), 1'b1);
        wait_start("char2", lat);
        chk("char2_width", op_width, 16'd0);
        chk("char2_dest", op_dest_addr, 26'h0);
        chk("char2_trans", op_trans, 9'h1FF);
        finish_op("char2", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
